hdlc_line_monitor: RTL and testbench
====================================

// Module: hdlc_line_monitor
// PURPOSE
// Synthesisable, multi-channel HDLC serial-line monitor. Hardware successor to the simulation-only Rx/Tx checks.
// Per channel: tracks flag/abort/idle, counts destuffed frame bits, flags malformed frames, keeps event counters.
// Sits passively on the Rx or Tx bit stream of each HDLC channel. Counters are readable through a registered port.
// PARAMETERS
// CH     2   number of monitored serial channels (1..8)
// LEN_W  12  width of destuffed frame-length counter in bits; saturates at 2**LEN_W-1
// CNT_W  16  width of each event counter; saturates at 2**CNT_W-1
// MIN_LEN 32 minimum legal destuffed frame length in bits (16 data + 16 FCS)
// PORTS
// Clk       in   1          system clock, all logic on posedge
// Rst       in   1          asynchronous reset, active low
// Line      in   CH         serial bit per channel (Rx or Tx line)
// BitEn     in   CH         per-channel bit strobe; Line[c] sampled only when BitEn[c]=1
// Clear     in   1          synchronous clear of all event counters (state machines unaffected)
// RdCh      in   $clog2(CH) channel select for counter read (use width 1 when CH=1)
// RdSel     in   2          0=frames ok, 1=aborts, 2=frame errors, 3=flags
// RdData    out  CNT_W      selected counter, registered, 1-cycle latency
// FlagDet   out  CH         1-cycle pulse: flag 01111110 completed
// AbortDet  out  CH         1-cycle pulse: 7th consecutive one seen while in frame
// FrameEnd  out  CH         1-cycle pulse: closing flag ended a non-empty frame
// FrameErr  out  CH         valid with FrameEnd: length <MIN_LEN or not a multiple of 8
// FrameLen  out  CH*LEN_W   destuffed data length of the ended frame, valid with FrameEnd, held until next FrameEnd
// Idle      out  CH         level: >=15 consecutive ones since the last zero
// BEHAVIOUR
// Reset: all outputs 0; shift regs 8'h00; ones counters 0; FSM HUNT; counters 0.
// Per channel on BitEn=1: sr<={sr[6:0],Line}; ones<=Line ? sat15(ones+1) : 0.
// Flag: new sr==8'h7E. Abort: ones reaches 7. Idle: ones==15; Idle falls on the first 0 sampled.
// Every output pulse is registered: asserted on the cycle after the sampling cycle, for exactly one Clk.
// Stuffing: a 0 sampled with ones==5 (before the update) is a stuffed zero and is not counted.
// All other bits in FRAME increment bitcnt (saturating).
// FSM per channel: HUNT, FLAG, FRAME.
//   HUNT : flag -> FLAG. All other bits are ignored.
//   FLAG : flag -> FLAG (shared/back-to-back flags, no FrameEnd); abort -> HUNT;
//          non-flag bit -> FRAME, bitcnt<=1 if counted else 0.
//   FRAME: flag -> FLAG with FrameEnd=1, FrameLen=bitcnt+1-8 (closing-flag bits removed).
//          If bitcnt+1-8 == 0, no FrameEnd is produced.
//          FrameErr=(len<MIN_LEN)||(len[2:0]!=0) || bitcnt saturated. Flag also pulses FlagDet.
//   FRAME: abort -> HUNT, AbortDet=1, no FrameEnd.
// Sampling cycle for a channel with BitEn=0: state is held, no pulses.
// Counters (per channel): frames-ok +1 on FrameEnd&!FrameErr; errors +1 on FrameEnd&FrameErr.
//   aborts +1 on AbortDet; flags +1 on FlagDet; all saturate, never wrap.
// Clear coincident with an increment: Clear wins, counter becomes 0.
// RdData<=counter[RdCh][RdSel] every cycle. RdCh>=CH returns 0.
// Channels are fully independent; simultaneous events on different channels all counted in the same cycle.
// Async reset mid-frame: everything returns to the reset state immediately; no pulse on release.
// TESTING
// 1 Reset, Line=1 with BitEn=1 for 15 bits -> Idle[0]=1 the cycle after the 15th bit; first 0 clears it.
// 2 7E, 32 data bits (8'hA5x4), 7E -> FlagDet x2, FrameEnd=1, FrameErr=0, FrameLen=32, frames-ok=1.
// 3 Data 8'hFF,8'hFF,8'h3E,8'h7C stuffed -> FrameLen=32, FrameErr=0, zeros after 5 ones not counted.
// 4 7E, 20 bits, then 7 ones -> AbortDet the cycle after the 7th one, no FrameEnd, aborts=1, FSM HUNT.
// 5 7E, 7E, 7E (shared flags), then 7E, 36 bits, 7E -> flags=5, one FrameEnd, FrameLen=36, FrameErr=1.
// 6 Ch0 and ch1 end frames on the same cycle, Clear asserted on that cycle, BitEn toggling
//   -> both counters read 0; RdCh=1, RdSel=3 returns value one cycle later.

Source files
------------

// File: rtl/hdlc_line_monitor_if.sv
// Bit-stream, counter-read and event signals of the HDLC line monitor.
// master drives the serial lines and reads counters; slave is the monitor.
interface hdlc_line_monitor_if #(
   parameter int CH    = 2,
   parameter int LEN_W = 12,
   parameter int CNT_W = 16
);
   localparam int RD_W = (CH > 1) ? $clog2(CH) : 1;

   logic [CH-1:0]       Line;
   logic [CH-1:0]       BitEn;
   logic                Clear;
   logic [RD_W-1:0]     RdCh;
   logic [1:0]          RdSel;
   logic [CNT_W-1:0]    RdData;
   logic [CH-1:0]       FlagDet;
   logic [CH-1:0]       AbortDet;
   logic [CH-1:0]       FrameEnd;
   logic [CH-1:0]       FrameErr;
   logic [CH*LEN_W-1:0] FrameLen;
   logic [CH-1:0]       Idle;

   modport master (
      output Line, BitEn, Clear, RdCh, RdSel,
      input  RdData, FlagDet, AbortDet, FrameEnd, FrameErr, FrameLen, Idle
   );
   modport slave (
      input  Line, BitEn, Clear, RdCh, RdSel,
      output RdData, FlagDet, AbortDet, FrameEnd, FrameErr, FrameLen, Idle
   );
endinterface

// File: rtl/hdlc_line_monitor.sv
// Passive multi-channel HDLC monitor: flag/abort/idle detection, destuffed
// frame length checks and saturating per-channel event counters.
module hdlc_lm_chan #(
   parameter int LEN_W   = 12,
   parameter int CNT_W   = 16,
   parameter int MIN_LEN = 32
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  line,
   input  logic                  bit_en,
   input  logic                  clear,
   output logic                  flag_det,
   output logic                  abort_det,
   output logic                  frame_end,
   output logic                  frame_err,
   output logic                  idle,
   output logic [LEN_W-1:0]      frame_len,
   output logic [3:0][CNT_W-1:0] cnt
);
   localparam logic [1:0] S_HUNT  = 2'd0;
   localparam logic [1:0] S_FLAG  = 2'd1;
   localparam logic [1:0] S_FRAME = 2'd2;
   localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [7:0]       sr, sr_nx;
   logic [3:0]       ones, ones_nx;
   logic [1:0]       state, state_nx;
   logic [LEN_W-1:0] bitcnt, bitcnt_nx, cnt_inc, end_len;
   logic             is_flag, is_abort, stuffed;
   logic             flag_p, abort_p, end_p, err_p;
   logic [3:0]       inc;

   assign sr_nx    = {sr[6:0], line};
   assign ones_nx  = line ? ((ones == 4'd15) ? ones : ones + 4'd1) : 4'd0;
   assign is_flag  = (sr_nx == 8'h7E);
   assign is_abort = line && (ones == 4'd6);
   assign stuffed  = !line && (ones == 4'd5);
   assign cnt_inc  = (bitcnt == LEN_MAX) ? bitcnt : bitcnt + LEN_W'(1);
   // the closing flag's eight bits were counted as data until it completed
   assign end_len  = cnt_inc - LEN_W'(8);
   assign err_p    = (end_len < LEN_W'(MIN_LEN)) || (end_len[2:0] != 3'd0) ||
                     (cnt_inc == LEN_MAX);
   assign idle     = (ones == 4'd15);
   assign inc      = {flag_p, end_p & err_p, abort_p, end_p & !err_p};

   always_comb begin
      state_nx  = state;
      bitcnt_nx = bitcnt;
      flag_p    = 1'b0;
      abort_p   = 1'b0;
      end_p     = 1'b0;
      if (bit_en) begin
         case (state)
            S_HUNT: if (is_flag) begin
               state_nx = S_FLAG;
               flag_p   = 1'b1;
            end
            S_FLAG: if (is_flag) flag_p = 1'b1;
               else if (is_abort) state_nx = S_HUNT;
               else begin
                  state_nx  = S_FRAME;
                  bitcnt_nx = stuffed ? '0 : LEN_W'(1);
               end
            S_FRAME: if (is_flag) begin
               state_nx = S_FLAG;
               flag_p   = 1'b1;
               end_p    = (cnt_inc > LEN_W'(8));
            end else if (is_abort) begin
               state_nx = S_HUNT;
               abort_p  = 1'b1;
            end else if (!stuffed) bitcnt_nx = cnt_inc;
            default: state_nx = S_HUNT;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         sr        <= 8'h00;
         ones      <= 4'd0;
         state     <= S_HUNT;
         bitcnt    <= '0;
         flag_det  <= 1'b0;
         abort_det <= 1'b0;
         frame_end <= 1'b0;
         frame_err <= 1'b0;
         frame_len <= '0;
      end else begin
         if (bit_en) begin
            sr   <= sr_nx;
            ones <= ones_nx;
         end
         state     <= state_nx;
         bitcnt    <= bitcnt_nx;
         flag_det  <= flag_p;
         abort_det <= abort_p;
         frame_end <= end_p;
         frame_err <= end_p & err_p;
         if (end_p) frame_len <= end_len;
      end
   end

   // 0=frames ok, 1=aborts, 2=frame errors, 3=flags; clear beats increment
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) cnt <= '0;
      else begin
         for (int k = 0; k < 4; k++) begin
            if (clear) cnt[k] <= '0;
            else if (inc[k] && (cnt[k] != CNT_MAX)) cnt[k] <= cnt[k] + CNT_W'(1);
         end
      end
   end
endmodule

module hdlc_line_monitor #(
   parameter int CH      = 2,
   parameter int LEN_W   = 12,
   parameter int CNT_W   = 16,
   parameter int MIN_LEN = 32
) (
   input logic           Clk,
   input logic           Rst,
   hdlc_line_monitor_if.slave bus
);
   localparam int RD_W = (CH > 1) ? $clog2(CH) : 1;

   logic [CH-1:0][3:0][CNT_W-1:0] cnt_all;
   logic [CH-1:0][LEN_W-1:0]      len_all;
   logic [CH-1:0] flag_det, abort_det, frame_end, frame_err, idle;

   for (genvar c = 0; c < CH; c++) begin : g_ch
      hdlc_lm_chan #(.LEN_W(LEN_W), .CNT_W(CNT_W), .MIN_LEN(MIN_LEN)) u_chan (
         .Clk       (Clk),
         .Rst       (Rst),
         .line      (bus.Line[c]),
         .bit_en    (bus.BitEn[c]),
         .clear     (bus.Clear),
         .flag_det  (flag_det[c]),
         .abort_det (abort_det[c]),
         .frame_end (frame_end[c]),
         .frame_err (frame_err[c]),
         .idle      (idle[c]),
         .frame_len (len_all[c]),
         .cnt       (cnt_all[c])
      );
   end

   assign bus.FlagDet  = flag_det;
   assign bus.AbortDet = abort_det;
   assign bus.FrameEnd = frame_end;
   assign bus.FrameErr = frame_err;
   assign bus.Idle     = idle;
   assign bus.FrameLen = len_all;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) bus.RdData <= '0;
      else if ({1'b0, bus.RdCh} < (RD_W+1)'(CH)) bus.RdData <= cnt_all[bus.RdCh][bus.RdSel];
      else bus.RdData <= '0;
   end
endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Scoreboard bench for hdlc_line_monitor: expected frame-ends are queued as
// frames are sent and popped when the monitor reports FrameEnd.
module tb_hdlc_line_monitor;
   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   hdlc_line_monitor_if #(.CH(2), .LEN_W(12), .CNT_W(16)) bus ();
   hdlc_line_monitor #(.CH(2), .LEN_W(12), .CNT_W(16), .MIN_LEN(32)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   typedef struct packed { logic [11:0] len; logic err; } fe_t;
   fe_t  q0[$];
   fe_t  q1[$];
   logic dbits[$];
   int   checks = 0, errors = 0;
   int   flag_cnt[2], abort_cnt[2], end_cnt[2];

   always @(negedge Clk) begin
      fe_t e;
      logic [11:0] got_len;
      if (Rst) begin
         for (int c = 0; c < 2; c++) begin
            if (bus.FlagDet[c])  flag_cnt[c]++;
            if (bus.AbortDet[c]) abort_cnt[c]++;
            if (bus.FrameEnd[c]) begin
               end_cnt[c]++;
               checks++;
               if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
                  errors++;
                  $display("FAIL frame_end_unexpected ch%0d: got FrameEnd=1, required 0", c);
               end else begin
                  if (c == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  got_len = bus.FrameLen[c*12 +: 12];
                  if (got_len !== e.len || bus.FrameErr[c] !== e.err) begin
                     errors++;
                     $display("FAIL frame_end ch%0d: got len=%0d err=%b, required len=%0d err=%b",
                              c, got_len, bus.FrameErr[c], e.len, e.err);
                  end
               end
            end
         end
      end
   end

   task automatic zero_soft();
      for (int c = 0; c < 2; c++) begin
         flag_cnt[c] = 0; abort_cnt[c] = 0; end_cnt[c] = 0;
      end
   endtask

   task automatic send_bit(input logic [1:0] chm, input logic b, input int gap);
      bus.Line  = {2{b}};
      bus.BitEn = chm;
      @(posedge Clk); #1;
      bus.BitEn = 2'b00;
      repeat (gap) begin @(posedge Clk); #1; end
   endtask

   task automatic send_flag(input logic [1:0] chm, input int gap);
      logic [7:0] f;
      f = 8'h7E;
      for (int i = 7; i >= 0; i--) send_bit(chm, f[i], gap);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) dbits.push_back(b[i]);
   endtask

   task automatic push_alt(input int n);
      for (int i = 0; i < n; i++) dbits.push_back(logic'(i % 2 == 0));
   endtask

   // transmitter-side stuffing: a zero after every five consecutive ones
   task automatic send_data(input logic [1:0] chm, input int gap);
      int run;
      run = 0;
      foreach (dbits[i]) begin
         send_bit(chm, dbits[i], gap);
         if (dbits[i]) begin
            run++;
            if (run == 5) begin send_bit(chm, 1'b0, gap); run = 0; end
         end else run = 0;
      end
      dbits.delete();
   endtask

   task automatic clear_counters();
      bus.Clear = 1'b1;
      @(posedge Clk); #1;
      bus.Clear = 1'b0;
      zero_soft();
   endtask

   task automatic read_cnt(input int ch, input int sel, output logic [15:0] v);
      bus.RdCh  = 1'(ch);
      bus.RdSel = 2'(sel);
      @(posedge Clk); #1;
      v = bus.RdData;
   endtask

   task automatic check_val(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      Rst = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checks++;
      if ({bus.FlagDet, bus.AbortDet, bus.FrameEnd, bus.FrameErr, bus.Idle} !== 10'd0 ||
          bus.FrameLen !== 24'd0 || bus.RdData !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: got flag=%b abort=%b end=%b err=%b idle=%b len=%h rd=%h, required all 0",
                  bus.FlagDet, bus.AbortDet, bus.FrameEnd, bus.FrameErr, bus.Idle, bus.FrameLen, bus.RdData);
      end
      Rst = 1'b1;
      @(posedge Clk); #1;
      zero_soft();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 14; i++) send_bit(2'b01, 1'b1, 0);
      check_val("idle_after_14", int'(bus.Idle[0]), 0);
      send_bit(2'b01, 1'b1, 0);
      check_val("idle_after_15", int'(bus.Idle[0]), 1);
      check_val("idle_ch1_quiet", int'(bus.Idle[1]), 0);
      send_bit(2'b01, 1'b1, 0);
      send_bit(2'b01, 1'b1, 0);
      check_val("idle_saturated", int'(bus.Idle[0]), 1);
      send_bit(2'b01, 1'b0, 0);
      check_val("idle_falls_on_zero", int'(bus.Idle[0]), 0);
   endtask

   task automatic test_frame();
      logic [15:0] v;
      clear_counters();
      send_flag(2'b01, 0);
      for (int i = 0; i < 4; i++) push_byte(8'hA5);
      q0.push_back('{len: 12'd32, err: 1'b0});
      send_data(2'b01, 0);
      send_flag(2'b01, 0);
      repeat (2) @(posedge Clk); #1;
      check_val("frame_flagdet", flag_cnt[0], 2);
      check_val("frame_end_count", end_cnt[0], 1);
      check_val("frame_queue_drained", q0.size(), 0);
      read_cnt(0, 0, v);
      check_val("frame_ok_counter", int'(v), 1);
      read_cnt(0, 2, v);
      check_val("frame_err_counter", int'(v), 0);
   endtask

   task automatic test_stuffing();
      logic [15:0] v;
      clear_counters();
      send_flag(2'b01, 1);
      push_byte(8'hFF); push_byte(8'hFF); push_byte(8'h3E); push_byte(8'h7C);
      q0.push_back('{len: 12'd32, err: 1'b0});
      send_data(2'b01, 1);
      send_flag(2'b01, 1);
      repeat (2) @(posedge Clk); #1;
      check_val("stuff_end_count", end_cnt[0], 1);
      check_val("stuff_abort_none", abort_cnt[0], 0);
      read_cnt(0, 0, v);
      check_val("stuff_ok_counter", int'(v), 1);
   endtask

   task automatic test_abort();
      logic [15:0] v;
      clear_counters();
      send_flag(2'b01, 0);
      push_alt(20);
      send_data(2'b01, 0);
      for (int i = 0; i < 6; i++) send_bit(2'b01, 1'b1, 0);
      check_val("abort_not_early", int'(bus.AbortDet[0]), 0);
      send_bit(2'b01, 1'b1, 0);
      check_val("abort_pulse", int'(bus.AbortDet[0]), 1);
      @(posedge Clk); #1;
      check_val("abort_pulse_width", int'(bus.AbortDet[0]), 0);
      read_cnt(0, 1, v);
      check_val("abort_counter", int'(v), 1);
      // now hunting: a following flag must not close a frame
      send_bit(2'b01, 1'b0, 0);
      send_flag(2'b01, 0);
      repeat (2) @(posedge Clk); #1;
      check_val("abort_no_frame_end", end_cnt[0], 0);
      check_val("abort_then_flag", flag_cnt[0], 2);
   endtask

   task automatic test_shared_flags();
      logic [15:0] v;
      clear_counters();
      for (int i = 0; i < 4; i++) send_flag(2'b01, 0);
      push_alt(36);
      q0.push_back('{len: 12'd36, err: 1'b1});
      send_data(2'b01, 0);
      send_flag(2'b01, 0);
      repeat (2) @(posedge Clk); #1;
      check_val("shared_end_count", end_cnt[0], 1);
      read_cnt(0, 3, v);
      check_val("shared_flags_counter", int'(v), 5);
      read_cnt(0, 2, v);
      check_val("shared_err_counter", int'(v), 1);
      read_cnt(0, 0, v);
      check_val("shared_ok_counter", int'(v), 0);
   endtask

   task automatic test_back_to_back();
      logic [15:0] v;
      logic [7:0]  f;
      f = 8'h7E;
      clear_counters();
      send_flag(2'b11, 1);
      for (int i = 0; i < 5; i++) push_byte(8'hA5);
      q0.push_back('{len: 12'd40, err: 1'b0});
      q1.push_back('{len: 12'd40, err: 1'b0});
      send_data(2'b11, 1);
      for (int i = 7; i > 0; i--) send_bit(2'b11, f[i], 1);
      bus.Clear = 1'b1;
      send_bit(2'b11, 1'b0, 0);
      @(posedge Clk); #1;
      bus.Clear = 1'b0;
      @(posedge Clk); #1;
      check_val("b2b_end_ch0", end_cnt[0], 1);
      check_val("b2b_end_ch1", end_cnt[1], 1);
      read_cnt(0, 0, v);
      check_val("b2b_clear_ok_ch0", int'(v), 0);
      read_cnt(1, 0, v);
      check_val("b2b_clear_ok_ch1", int'(v), 0);
      read_cnt(1, 3, v);
      check_val("b2b_clear_flags_ch1", int'(v), 0);
      // ch1 only: one more frame and an extra flag, counters now differ
      for (int i = 0; i < 4; i++) push_byte(8'hA5);
      q1.push_back('{len: 12'd32, err: 1'b0});
      send_data(2'b10, 1);
      send_flag(2'b10, 1);
      send_flag(2'b10, 1);
      @(posedge Clk); #1;
      read_cnt(1, 0, v);
      check_val("b2b_ok_ch1", int'(v), 1);
      bus.RdSel = 2'd3;
      #1;
      check_val("rd_latency_hold", int'(bus.RdData), 1);
      @(posedge Clk); #1;
      check_val("rd_latency_flags", int'(bus.RdData), 2);
      check_val("b2b_queues_drained", q0.size() + q1.size(), 0);
   endtask

   task automatic test_reset_midframe();
      send_flag(2'b01, 0);
      push_alt(10);
      send_data(2'b01, 0);
      #2;
      Rst = 1'b0;
      #1;
      check_val("midreset_len", int'(bus.FrameLen), 0);
      check_val("midreset_rddata", int'(bus.RdData), 0);
      @(posedge Clk); #1;
      Rst = 1'b1;
      zero_soft();
      @(posedge Clk); #1;
      send_bit(2'b01, 1'b0, 0);
      send_flag(2'b01, 0);
      repeat (2) @(posedge Clk); #1;
      check_val("midreset_no_end", end_cnt[0], 0);
      check_val("midreset_flag", flag_cnt[0], 1);
   endtask

   initial begin
      bus.Line  = 2'b00;
      bus.BitEn = 2'b00;
      bus.Clear = 1'b0;
      bus.RdCh  = 1'b0;
      bus.RdSel = 2'd0;
      test_reset();
      test_idle();
      test_frame();
      test_stuffing();
      test_abort();
      test_shared_flags();
      test_back_to_back();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
